// File: rtl/sipo_pkg.sv
// ----------------------------------------------------------------------------
// Package: sipo_pkg
// Shared definitions for the serial-in/parallel-out deserialiser.
//   - FSM state encodings (S_IDLE, S_SHIFT, S_PAR)
//   - cnt_width(): bit-count width for a given word width, $clog2(WIDTH+1)
// Optional feature macro used by the importers: PARITY_CHECK_EN.
// ----------------------------------------------------------------------------
package sipo_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_PAR   = 2'd2;

    localparam int unsigned DEF_WIDTH = 4;

    // Wide enough to hold WIDTH itself (the parity slot index).
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// ----------------------------------------------------------------------------
// Module: sipo_out_reg
// One-entry valid/ready holding register for assembled words, plus the
// sticky overrun flag.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_flush           clears overrun (held word untouched)
//   i_word_valid      a completed word is offered this cycle
//   i_word            the completed word
//   i_par             parity result for the word (PARITY_CHECK_EN only)
//   i_ready           consumer ready
//   o_dout/o_valid    held word and its valid flag
//   o_overrun         sticky: a completed word was dropped
//   o_par_err         parity error of the held word (PARITY_CHECK_EN only)
// Macro: PARITY_CHECK_EN adds i_par / o_par_err.
// ----------------------------------------------------------------------------
module sipo_out_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_word_valid,
    input  logic [WIDTH-1:0] i_word,
`ifdef PARITY_CHECK_EN
    input  logic             i_par,
    output logic             o_par_err,
`endif
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_valid,
    output logic             o_overrun
);

    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_overrun;
    logic             w_load;

    // A slot frees up in the same cycle it is handed off, so words can
    // stream back-to-back without a bubble.
    assign w_load = i_word_valid & (~r_valid | i_ready);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_dout  <= i_word;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // A completed word can never coincide with flush (flush wins over the bit),
    // so the ordering here only matters for rst.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_overrun <= 1'b0;
        end else if (i_word_valid && !w_load) begin
            r_overrun <= 1'b1;
        end
    end

`ifdef PARITY_CHECK_EN
    logic r_par_err;

    // Dropped words leave the flag alone; it tracks the held word only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_par_err <= 1'b0;
        end else if (w_load) begin
            r_par_err <= i_par;
        end
    end

    assign o_par_err = r_par_err;
`endif

    assign o_dout    = r_dout;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/sipo_deser_4bit.sv
// ----------------------------------------------------------------------------
// Module: sipo_deser_4bit
// Serial-in, parallel-out receiver. Shifts MSB-first bits in on each accepted
// strobe, frames every WIDTH bits into a word and hands it to a one-entry
// valid/ready output register.
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   s_in         serial data bit
//   s_valid      s_in is taken on edges where s_valid=1
//   flush        drop the partial word, restart framing, clear overrun
//   dout         assembled word, first-received bit in dout[WIDTH-1]
//   dout_valid   word held in the output register
//   dout_ready   consumer accepts on dout_valid & dout_ready
//   overrun      sticky: a completed word was dropped
//   par_err      even-parity error for the held word (PARITY_CHECK_EN only)
// Macro: PARITY_CHECK_EN appends an even-parity bit to each frame.
// ----------------------------------------------------------------------------
module sipo_deser_4bit
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_in,
    input  logic             s_valid,
    input  logic             flush,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
`ifdef PARITY_CHECK_EN
    output logic             par_err,
`endif
    output logic             overrun
);

    localparam int unsigned        CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sr;

    logic             w_accept;
    logic             w_word_done;
    logic [WIDTH-1:0] w_word;

    // flush has priority: a bit strobed alongside it is discarded.
    assign w_accept = s_valid & ~flush;

`ifdef PARITY_CHECK_EN
    logic w_par;

    // In S_PAR the data bits are already complete in r_sr; the incoming bit is
    // the parity bit and is only folded into the check.
    assign w_word_done = w_accept && (r_state == S_PAR);
    assign w_word      = r_sr;
    assign w_par       = ^{r_sr, s_in};
`else
    // WIDTH >= 2, so the last bit always arrives while in S_SHIFT.
    assign w_word_done = w_accept && (r_state == S_SHIFT) && (r_cnt == CNT_LAST);
    assign w_word      = {r_sr[WIDTH-2:0], s_in};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sr    <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (s_valid) begin
`ifdef PARITY_CHECK_EN
            if (r_state == S_PAR) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                r_sr <= {r_sr[WIDTH-2:0], s_in};
                if (r_cnt == CNT_LAST) begin
                    r_state <= S_PAR;
                    r_cnt   <= CNT_W'(WIDTH);
                end else begin
                    r_state <= S_SHIFT;
                    r_cnt   <= r_cnt + CNT_ONE;
                end
            end
`else
            r_sr <= {r_sr[WIDTH-2:0], s_in};
            if (r_cnt == CNT_LAST) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= S_SHIFT;
                r_cnt   <= r_cnt + CNT_ONE;
            end
`endif
        end
    end

    sipo_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_flush      (flush),
        .i_word_valid (w_word_done),
        .i_word       (w_word),
`ifdef PARITY_CHECK_EN
        .i_par        (w_par),
        .o_par_err    (par_err),
`endif
        .i_ready      (dout_ready),
        .o_dout       (dout),
        .o_valid      (dout_valid),
        .o_overrun    (overrun)
    );

endmodule

// File: tb/tb_sipo_deser_4bit.sv
// ----------------------------------------------------------------------------
// Testbench: tb_sipo_deser_4bit
// Directed stimulus for sipo_deser_4bit with a word scoreboard: expected
// words are queued as frames are sent and popped on each output handshake.
// Macro: PARITY_CHECK_EN adds the parity bit to each frame and par_err checks.
// ----------------------------------------------------------------------------
module tb_sipo_deser_4bit;

`ifdef PARITY_CHECK_EN
    localparam int FRAME = 5;
`else
    localparam int FRAME = 4;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       s_in;
    logic       s_valid;
    logic       flush;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       overrun;
`ifdef PARITY_CHECK_EN
    logic       par_err;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [4:0] sb[$];
    time        pop_t[$];
    logic [4:0] exp_e;

    always #5 clk = ~clk;

    sipo_deser_4bit #(
        .WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_in       (s_in),
        .s_valid    (s_valid),
        .flush      (flush),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
`ifdef PARITY_CHECK_EN
        .par_err    (par_err),
`endif
        .overrun    (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        s_in    = b;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        s_in    = 1'b0;
    endtask

    // Sends one frame MSB-first; gap inserts an idle cycle (s_valid=0, inverted
    // s_in) after each data bit; bad_par sends odd parity in parity builds.
    task automatic send_word(input logic [3:0] w, input bit gap, input bit bad_par,
                             input bit push);
        logic [3:0] v;
        v = w;
        for (int i = 3; i >= 0; i--) begin
`ifndef PARITY_CHECK_EN
            if (i == 0 && push) sb.push_back({1'b0, w});
`endif
            send_bit(v[i]);
            if (gap && i != 0) begin
                s_in = ~v[i];
                step();
            end
        end
`ifdef PARITY_CHECK_EN
        if (push) sb.push_back({bad_par, w});
        send_bit((^w) ^ bad_par);
`else
        if (bad_par) s_in = 1'b0;
`endif
    endtask

    // Output-side monitor: every handshake must match the oldest queued word.
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_unexpected observed=%0h expected=none", dout);
            end else begin
                exp_e = sb.pop_front();
                pop_t.push_back($time);
                check("sb_word", {28'd0, dout}, {28'd0, exp_e[3:0]});
`ifdef PARITY_CHECK_EN
                check("sb_par", {31'd0, par_err}, {31'd0, exp_e[4]});
`endif
            end
        end
    end

    initial begin
        rst        = 1'b1;
        s_in       = 1'b0;
        s_valid    = 1'b0;
        flush      = 1'b0;
        dout_ready = 1'b0;
        repeat (3) step();
        check("rst_dout", {28'd0, dout}, 32'd0);
        check("rst_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
`ifdef PARITY_CHECK_EN
        check("rst_par_err", {31'd0, par_err}, 32'd0);
`endif
        rst = 1'b0;
        step();
        check("idle_valid", {31'd0, dout_valid}, 32'd0);

        // Basic word, one-cycle latency and single-cycle valid pulse.
        dout_ready = 1'b1;
        send_word(4'b1011, 1'b0, 1'b0, 1'b1);
        check("t1_valid", {31'd0, dout_valid}, 32'd1);
        check("t1_dout", {28'd0, dout}, 32'hb);
        step();
        check("t1_pulse", {31'd0, dout_valid}, 32'd0);

        // Strobe gaps are ignored.
        send_word(4'b0111, 1'b1, 1'b0, 1'b1);
        check("t2_dout", {28'd0, dout}, 32'h7);
        step();
        check("t2_pulse", {31'd0, dout_valid}, 32'd0);

        // Stalled consumer: second word dropped, overrun sticks until flush.
        dout_ready = 1'b0;
        send_word(4'b1111, 1'b0, 1'b0, 1'b1);
        check("t3_valid", {31'd0, dout_valid}, 32'd1);
        check("t3_no_ovr", {31'd0, overrun}, 32'd0);
        send_word(4'b0000, 1'b0, 1'b0, 1'b0);
        check("t3_ovr", {31'd0, overrun}, 32'd1);
        check("t3_hold", {28'd0, dout}, 32'hf);
        check("t3_hold_valid", {31'd0, dout_valid}, 32'd1);
        dout_ready = 1'b1;
        step();
        check("t3_consumed", {31'd0, dout_valid}, 32'd0);
        check("t3_ovr_sticky", {31'd0, overrun}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t3_flush_ovr", {31'd0, overrun}, 32'd0);

        // Partial word then flush (with a strobed bit that must be discarded).
        send_bit(1'b1);
        send_bit(1'b1);
        flush   = 1'b1;
        s_valid = 1'b1;
        s_in    = 1'b1;
        step();
        flush   = 1'b0;
        s_valid = 1'b0;
        send_word(4'b0110, 1'b0, 1'b0, 1'b1);
        check("t4_dout", {28'd0, dout}, 32'h6);
        check("t4_valid", {31'd0, dout_valid}, 32'd1);
        step();

        // Back-to-back frames: valid once per frame, no overrun.
        send_word(4'b1011, 1'b0, 1'b0, 1'b1);
        send_word(4'b0110, 1'b0, 1'b0, 1'b1);
        check("t5_valid", {31'd0, dout_valid}, 32'd1);
        check("t5_no_ovr", {31'd0, overrun}, 32'd0);
        step();
        check("t5_spacing", 32'(pop_t[$] - pop_t[$-1]), 32'(FRAME * 10));

`ifdef PARITY_CHECK_EN
        send_word(4'b1011, 1'b0, 1'b0, 1'b1);
        check("t6_par_ok", {31'd0, par_err}, 32'd0);
        step();
        send_word(4'b1011, 1'b0, 1'b1, 1'b1);
        check("t6_par_bad", {31'd0, par_err}, 32'd1);
        check("t6_dout", {28'd0, dout}, 32'hb);
        step();
`endif

        // Reset mid-frame with a word held: everything returns to zero.
        dout_ready = 1'b0;
        send_word(4'b1011, 1'b0, 1'b1, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t7_dout", {28'd0, dout}, 32'd0);
        check("t7_valid", {31'd0, dout_valid}, 32'd0);
        check("t7_ovr", {31'd0, overrun}, 32'd0);
`ifdef PARITY_CHECK_EN
        check("t7_par_err", {31'd0, par_err}, 32'd0);
`endif
        dout_ready = 1'b1;
        send_word(4'b0110, 1'b0, 1'b0, 1'b1);
        check("t7_after_dout", {28'd0, dout}, 32'h6);
        step();
        step();

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
